// File: rtl/fifo_axis_drain.sv
// AXI-Stream drain stage for the user-area FIFO: 3-entry skid queue with
// optional packet framing enabled by the FIFO_DRAIN_TLAST_EN macro.
module fifo_axis_drain #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  input  logic [LEN_W-1:0]  pkt_len,
  output logic              sm_tvalid,
  output logic [DATA_W-1:0] sm_tdata,
  output logic              sm_tlast,
  input  logic              sm_tready,
  output logic [15:0]       pkt_cnt
);

  logic [DATA_W-1:0] mem_q [3];
  logic [1:0]        occ_q, occ_d;
  logic [1:0]        wr_ptr_q, wr_ptr_d;
  logic [1:0]        rd_ptr_q, rd_ptr_d;
  logic              infl_q, infl_d;
  logic [2:0]        fill;
  logic              pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Occupancy counts the in-flight word so a read is only issued when a slot
  // is guaranteed; this keeps fifo_rd_en independent of sm_tready.
  always_comb begin
    fill       = {1'b0, occ_q} + {2'b00, infl_q};
    fifo_rd_en = ~reset & ~fifo_empty & (fill < 3'd3);
    infl_d     = fifo_rd_en & ~fifo_empty;
    sm_tvalid  = (occ_q != 2'd0);
    sm_tdata   = mem_q[rd_ptr_q];
    pop        = sm_tvalid & sm_tready;
  end

  always_comb begin
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    unique case ({infl_q, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    if (infl_q) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop)    rd_ptr_d = next_ptr(rd_ptr_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q    <= '0;
      infl_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < 3; i++) mem_q[i] <= '0;
    end else begin
      occ_q    <= occ_d;
      infl_q   <= infl_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (infl_q) mem_q[wr_ptr_q] <= fifo_rd_data;
    end
  end

`ifdef FIFO_DRAIN_TLAST_EN
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  logic [LEN_W-1:0] beat_q, beat_d;
  logic [LEN_W-1:0] plen_q, plen_d;
  logic [LEN_W-1:0] plen_eff, plen_cur;
  logic [15:0]      pkt_cnt_q, pkt_cnt_d;

  // On the first beat the length comes straight from pkt_len so a one-beat
  // packet can assert tlast without waiting for plen_q to load.
  always_comb begin
    plen_eff  = (pkt_len == '0) ? ONE : pkt_len;
    plen_cur  = (beat_q == '0) ? plen_eff : plen_q;
    plen_d    = plen_cur;
    sm_tlast  = sm_tvalid & (beat_q == plen_cur - ONE);
    beat_d    = beat_q;
    pkt_cnt_d = pkt_cnt_q;
    if (pop) begin
      beat_d = sm_tlast ? '0 : beat_q + ONE;
      if (sm_tlast) pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
    pkt_cnt = pkt_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_q    <= '0;
      plen_q    <= '0;
      pkt_cnt_q <= '0;
    end else begin
      beat_q    <= beat_d;
      plen_q    <= plen_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end
`else
  logic unused_pkt_len;

  always_comb begin
    unused_pkt_len = ^pkt_len;
    sm_tlast       = 1'b0;
    pkt_cnt        = '0;
  end
`endif

endmodule

// File: tb/tb_fifo_axis_drain.sv
// Directed bench for fifo_axis_drain with a behavioural 1-cycle-latency FIFO
// and a negedge stream monitor; framing tests follow FIFO_DRAIN_TLAST_EN.
module tb_fifo_axis_drain;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data = '0;
  logic        fifo_empty;
  logic [8:0]  pkt_len = 9'd1;
  logic        sm_tvalid;
  logic [31:0] sm_tdata;
  logic        sm_tlast;
  logic        sm_tready = 1'b0;
  logic [15:0] pkt_cnt;

  int n_checks = 0;
  int n_errors = 0;

  fifo_axis_drain #(.DATA_W(32), .LEN_W(9)) dut (
    .clk(clk), .reset(reset),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .pkt_len(pkt_len),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
    .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: read data appears the cycle after an accepted strobe and is
  // held otherwise; reset empties it.
  logic [31:0] fmem [0:4095];
  int wr_idx = 0;
  int rd_idx = 0;
  assign fifo_empty = (wr_idx == rd_idx);

  always @(posedge clk or posedge reset) begin
    if (reset) rd_idx <= wr_idx;
    else if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= fmem[rd_idx];
      rd_idx       <= rd_idx + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] out_data [0:4095];
  logic        out_last [0:4095];
  int          out_cyc  [0:4095];
  int          out_cnt = 0;
  int          rd_acc = 0;
  int          outst = 0;
  int          viol = 0;
  int          stab_viol = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      outst      <= 0;
      prev_stall <= 1'b0;
    end else begin
      if (fifo_rd_en && outst >= 3) viol <= viol + 1;
      if (prev_stall && (!sm_tvalid || sm_tdata !== prev_data || sm_tlast !== prev_last))
        stab_viol <= stab_viol + 1;
      if (sm_tvalid && sm_tready) begin
        out_data[out_cnt] <= sm_tdata;
        out_last[out_cnt] <= sm_tlast;
        out_cyc[out_cnt]  <= cyc;
        out_cnt           <= out_cnt + 1;
      end
      if (fifo_rd_en && !fifo_empty) rd_acc <= rd_acc + 1;
      outst      <= outst + int'(fifo_rd_en && !fifo_empty) - int'(sm_tvalid && sm_tready);
      prev_stall <= sm_tvalid && !sm_tready;
      prev_data  <= sm_tdata;
      prev_last  <= sm_tlast;
    end
  end

  task automatic push(input logic [31:0] w);
    fmem[wr_idx] = w;
    wr_idx = wr_idx + 1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_pops(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (out_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    sm_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1 push(32'h55);
    #1;
    n_checks++; if (fifo_rd_en !== 1'b0) begin n_errors++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
    n_checks++; if (sm_tvalid !== 1'b0) begin n_errors++; $display("FAIL reset_tvalid: got %b want 0", sm_tvalid); end
    n_checks++; if (sm_tlast !== 1'b0) begin n_errors++; $display("FAIL reset_tlast: got %b want 0", sm_tlast); end
    n_checks++; if (pkt_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); end
    n_checks++; if (sm_tdata !== 32'd0) begin n_errors++; $display("FAIL reset_tdata: got %h want 0", sm_tdata); end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_basic();
    int base, n;
    bit ok;
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33; exp_w[3] = 32'h44;
    sm_tready = 1'b1;
    @(posedge clk); #1;
    base = out_cnt;
    n = cyc;
    for (int i = 0; i < 4; i++) push(exp_w[i]);
    #1;
    n_checks++; if (fifo_rd_en !== 1'b1) begin n_errors++; $display("FAIL basic_rd_en_same_cycle: got %b want 1", fifo_rd_en); end
    wait_pops(base + 4, 20, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL basic_timeout: got %0d beats want 4", out_cnt - base); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_data[base+i] !== exp_w[i]) begin n_errors++; $display("FAIL basic_data[%0d]: got %h want %h", i, out_data[base+i], exp_w[i]); end
      n_checks++; if (out_cyc[base+i] !== n + 2 + i) begin n_errors++; $display("FAIL basic_cycle[%0d]: got %0d want %0d", i, out_cyc[base+i] - n, 2 + i); end
    end
    n_checks++; if (sm_tvalid !== 1'b0) begin n_errors++; $display("FAIL basic_idle_tvalid: got %b want 0", sm_tvalid); end
  endtask

  task automatic test_backpressure();
    int base, base_rd, r;
    bit ok;
    @(posedge clk); #1;
    sm_tready = 1'b0;
    base = out_cnt;
    base_rd = rd_acc;
    for (int i = 0; i < 10; i++) push(32'hA000_0000 + i);
    repeat (20) @(posedge clk);
    #1;
    n_checks++; if (rd_acc - base_rd !== 3) begin n_errors++; $display("FAIL bp_reads: got %0d want 3", rd_acc - base_rd); end
    n_checks++; if (fifo_rd_en !== 1'b0) begin n_errors++; $display("FAIL bp_rd_en_stalled: got %b want 0", fifo_rd_en); end
    n_checks++; if (sm_tvalid !== 1'b1) begin n_errors++; $display("FAIL bp_tvalid: got %b want 1", sm_tvalid); end
    n_checks++; if (sm_tdata !== 32'hA000_0000) begin n_errors++; $display("FAIL bp_head: got %h want a0000000", sm_tdata); end
    sm_tready = 1'b1;
    r = cyc;
    wait_pops(base + 10, 40, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL bp_timeout: got %0d beats want 10", out_cnt - base); end
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (out_data[base+i] !== 32'hA000_0000 + i) begin n_errors++; $display("FAIL bp_data[%0d]: got %h want %h", i, out_data[base+i], 32'hA000_0000 + i); end
      n_checks++; if (out_cyc[base+i] !== r + i) begin n_errors++; $display("FAIL bp_gap[%0d]: got cycle +%0d want +%0d", i, out_cyc[base+i] - r, i); end
    end
  endtask

  task automatic test_tlast();
    int base;
    bit ok;
`ifdef FIFO_DRAIN_TLAST_EN
    do_reset();
    sm_tready = 1'b1;
    pkt_len = 9'd3;
    base = out_cnt;
    for (int i = 0; i < 7; i++) push(32'hB0 + i);
    wait_pops(base + 7, 40, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL tlast3_timeout: got %0d beats want 7", out_cnt - base); end
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (out_last[base+i] !== ((i == 2) || (i == 5))) begin
        n_errors++; $display("FAIL tlast3_beat[%0d]: got %b want %b", i, out_last[base+i], (i == 2) || (i == 5));
      end
    end
    n_checks++; if (pkt_cnt !== 16'd2) begin n_errors++; $display("FAIL tlast3_pkt_cnt: got %0d want 2", pkt_cnt); end
    // Next packet already started with plen 3; a new pkt_len must not apply.
    pkt_len = 9'd5;
    push(32'hB7); push(32'hB8);
    wait_pops(base + 9, 20, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL tlast_mid_timeout: got %0d beats want 9", out_cnt - base); end
    n_checks++; if (out_last[base+7] !== 1'b0) begin n_errors++; $display("FAIL tlast_mid_beat8: got %b want 0", out_last[base+7]); end
    n_checks++; if (out_last[base+8] !== 1'b1) begin n_errors++; $display("FAIL tlast_mid_beat9: got %b want 1", out_last[base+8]); end
    n_checks++; if (pkt_cnt !== 16'd3) begin n_errors++; $display("FAIL tlast_mid_pkt_cnt: got %0d want 3", pkt_cnt); end

    do_reset();
    pkt_len = 9'd0;
    base = out_cnt;
    push(32'hC0); push(32'hC1);
    wait_pops(base + 2, 20, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL tlast0_timeout: got %0d beats want 2", out_cnt - base); end
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (out_last[base+i] !== 1'b1) begin n_errors++; $display("FAIL tlast0_beat[%0d]: got %b want 1", i, out_last[base+i]); end
    end
    n_checks++; if (pkt_cnt !== 16'd2) begin n_errors++; $display("FAIL tlast0_pkt_cnt: got %0d want 2", pkt_cnt); end
`else
    sm_tready = 1'b1;
    pkt_len = 9'd1;
    base = out_cnt;
    push(32'hD0); push(32'hD1); push(32'hD2);
    wait_pops(base + 3, 20, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL notlast_timeout: got %0d beats want 3", out_cnt - base); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (out_last[base+i] !== 1'b0) begin n_errors++; $display("FAIL notlast_beat[%0d]: got %b want 0", i, out_last[base+i]); end
    end
    n_checks++; if (pkt_cnt !== 16'd0) begin n_errors++; $display("FAIL notlast_pkt_cnt: got %0d want 0", pkt_cnt); end
`endif
  endtask

  task automatic test_random();
    int base, pushed;
    logic [31:0] exp_w [1000];
    bit done;
    base = out_cnt;
    pushed = 0;
    done = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      @(posedge clk); #1;
      if (out_cnt >= base + 1000) begin
        done = 1'b1;
        break;
      end
      sm_tready = 1'($urandom_range(0, 1));
      if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
        exp_w[pushed] = $urandom;
        push(exp_w[pushed]);
        pushed++;
      end
    end
    sm_tready = 1'b1;
    n_checks++; if (!done) begin n_errors++; $display("FAIL rand_timeout: got %0d beats want 1000", out_cnt - base); end
    for (int i = 0; i < 1000; i++) begin
      n_checks++; if (out_data[base+i] !== exp_w[i]) begin n_errors++; $display("FAIL rand_data[%0d]: got %h want %h", i, out_data[base+i], exp_w[i]); end
    end
    n_checks++; if (viol !== 0) begin n_errors++; $display("FAIL rand_rd_en_at_full: got %0d want 0", viol); end
    n_checks++; if (stab_viol !== 0) begin n_errors++; $display("FAIL rand_stall_stability: got %0d want 0", stab_viol); end
  endtask

  task automatic test_async_reset();
    int base, base_rd;
    bit ok;
    @(posedge clk); #1;
    sm_tready = 1'b0;
    base_rd = rd_acc;
    for (int i = 0; i < 10; i++) push(32'hE000_0000 + i);
    repeat (8) @(posedge clk);
    #1;
    n_checks++; if (rd_acc - base_rd !== 3) begin n_errors++; $display("FAIL areset_full: got %0d reads want 3", rd_acc - base_rd); end
    n_checks++; if (sm_tvalid !== 1'b1) begin n_errors++; $display("FAIL areset_pre_tvalid: got %b want 1", sm_tvalid); end
    #1 reset = 1'b1;
    #1;
    n_checks++; if (sm_tvalid !== 1'b0) begin n_errors++; $display("FAIL areset_tvalid_drop: got %b want 0", sm_tvalid); end
    n_checks++; if (fifo_rd_en !== 1'b0) begin n_errors++; $display("FAIL areset_rd_en: got %b want 0", fifo_rd_en); end
    n_checks++; if (sm_tdata !== 32'd0) begin n_errors++; $display("FAIL areset_tdata: got %h want 0", sm_tdata); end
    @(posedge clk); #1 reset = 1'b0;
    sm_tready = 1'b1;
    base = out_cnt;
    push(32'hF1); push(32'hF2); push(32'hF3);
    wait_pops(base + 3, 20, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL areset_timeout: got %0d beats want 3", out_cnt - base); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (out_data[base+i] !== 32'hF1 + i) begin n_errors++; $display("FAIL areset_data[%0d]: got %h want %h", i, out_data[base+i], 32'hF1 + i); end
    end
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (out_cnt - base !== 3) begin n_errors++; $display("FAIL areset_stale: got %0d beats want 3", out_cnt - base); end
    n_checks++; if (stab_viol !== 0) begin n_errors++; $display("FAIL areset_stability: got %0d want 0", stab_viol); end
    n_checks++; if (viol !== 0) begin n_errors++; $display("FAIL areset_rd_en_at_full: got %0d want 0", viol); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_tlast();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_axis_drain.md
# fifo_axis_drain

Downstream drain stage for the 32-bit, 512-deep user-area FIFO. It pulls words from the FIFO read port, which returns data one cycle after the read strobe, and buffers them in a 3-entry output queue. It presents them as an AXI-Stream master so the FIFO output can feed a stream consumer at one word per cycle. It also frames the stream into packets of programmable length and counts completed packets.

## Interface
- DATA_W, 32, data width; must match the FIFO word width.
- LEN_W, 9, width of the packet-length input and the beat counter.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- fifo_rd_en  out  1  FIFO read strobe; combinational from registered state and fifo_empty.
- fifo_rd_data  in  DATA_W  FIFO read data; valid the cycle after an accepted read.
- fifo_empty  in  1  FIFO empty flag.
- pkt_len  in  LEN_W  beats per packet; sampled on the first beat of each packet.
- sm_tvalid  out  1  stream valid.
- sm_tdata  out  DATA_W  stream data (queue head).
- sm_tlast  out  1  last beat of packet.
- sm_tready  in  1  stream ready.
- pkt_cnt  out  16  completed-packet counter; wraps 0xFFFF→0.

## Operation
- Output queue: 3 entries, circular, with registered occupancy occ (0..3) and a registered in-flight flag infl.
  - infl = previous-cycle fifo_rd_en & ~fifo_empty.
- Read issue: fifo_rd_en = ~fifo_empty & (occ + infl < 3).
  - fifo_rd_en has no combinational dependence on sm_tready.
  - The queue can never overflow.
- Capture: when infl=1, fifo_rd_data is written to the queue tail at the end of that cycle.
- Pop: sm_tvalid = (occ != 0). A pop occurs when sm_tvalid & sm_tready.
- Simultaneous capture and pop: occ is unchanged and both pointers advance.
- sm_tdata is the head entry and holds stable while sm_tvalid & ~sm_tready.
- Beat counter beat (LEN_W bits):
  - Cleared on reset.
  - Increments on each pop.
  - Returns to 0 on a pop with sm_tlast=1.
- Packet length: when beat==0, plen_q <= pkt_len (pkt_len==0 is treated as 1). Changing pkt_len mid-packet has no effect until the next packet.
- pkt_cnt increments on each pop with sm_tlast=1.
- Reset mid-operation:
  - occ, infl, pointers, beat and pkt_cnt clear to 0.
  - Queued and in-flight words are discarded.
  - The FIFO is reset from the same reset net.

## Timing
- Reset values:
  - fifo_rd_en=0 while reset is asserted (gated).
  - sm_tvalid=0, sm_tlast=0, pkt_cnt=0.
  - sm_tdata=0 (queue storage cleared).
- Latency: fifo_empty falls in cycle N → fifo_rd_en=1 in N → data captured at end of N+1 → sm_tvalid=1 in N+2.
- Throughput: 1 word/cycle sustained while the FIFO is non-empty and sm_tready=1. occ+infl settles at 2.
- Backpressure:
  - With sm_tready=0, at most 3 reads are issued; then fifo_rd_en=0.
  - The first read resumes in the cycle after the first pop.
- AXI-Stream rules:
  - sm_tvalid never deasserts without a pop.
  - sm_tdata and sm_tlast are stable while stalled.
- FIFO-empty edge: a read issued while fifo_empty=1 is not counted (infl stays 0), so the FIFO's held rd_data is never captured twice.

## Configuration
- FIFO_DRAIN_TLAST_EN defined:
  - sm_tlast = sm_tvalid & (beat == plen_q-1), with plen_q taken from pkt_len when beat==0.
  - pkt_cnt is active.
- Not defined:
  - The beat/length logic is removed.
  - sm_tlast is tied 0 and pkt_cnt is tied 0.
  - The data path and timing are unchanged.

## Test plan
- Reset then 4 FIFO writes 0x11,0x22,0x33,0x44 with sm_tready=1 → first sm_tvalid 2 cycles after fifo_empty falls; beats 0x11..0x44 on 4 consecutive cycles; then sm_tvalid=0.
- 10 words queued, sm_tready=0 for 20 cycles → exactly 3 fifo_rd_en pulses; sm_tdata holds the first word; on release all 10 words arrive in order with no gaps.
- TLAST_EN, pkt_len=3, 7 words streamed → sm_tlast on beats 3 and 6; pkt_cnt=2; beat 7 outstanding with beat counter=1.
- TLAST_EN, pkt_len=0, 2 words → sm_tlast on every beat; pkt_cnt=2.
- Random sm_tready (50%) over 1000 random words → output sequence equals input sequence; fifo_rd_en never asserted while occ+infl=3.
- Reset asserted asynchronously mid-stream with occ=3 → sm_tvalid drops immediately, before the next edge; after release, new FIFO data streams with no stale word.
